// File: rtl/ift_sram_pkg.sv
// Shared types and helpers for the multi-taint IFT SRAM model.
// Holds the scrub FSM state encoding and the address-to-region mapping.
// No logic of its own; imported by the top module.
package ift_sram_pkg;

    // Scrub sweep FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    // Region index = top region_bits of the word address; 0 when there is a single region
    function automatic int unsigned region_of(
        input logic [31:0] addr,
        input int unsigned addr_width,
        input int unsigned region_bits
    );
        logic [31:0] shifted;
        logic [31:0] mask;
        if (region_bits == 0) begin
            return 0;
        end
        shifted = addr >> (addr_width - region_bits);
        mask    = (32'd1 << region_bits) - 32'd1;
        return shifted & mask;
    endfunction

endpackage

// File: rtl/ift_delay_line.sv
// Purpose: fixed-depth register pipe for read data and read taint.
// Latency: Depth cycles (Depth=0 is a plain wire).
// Backpressure: none; advances every cycle, cleared by synchronous reset.
module ift_delay_line #(
    parameter int Width = 1,
    parameter int Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    generate
        if (Depth == 0) begin : g_pass
            // Zero depth: clock and reset are intentionally unused
            logic w_unused;
            assign w_unused = clk_i ^ rst_i;
            assign q_o      = d_i;
        end else begin : g_pipe
            logic [Width-1:0] r_stage [Depth];

            // Shift the pipe one stage per cycle
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < Depth; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= d_i;
                    for (int i = 1; i < Depth; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q_o = r_stage[Depth-1];
        end
    endgenerate

endmodule

// File: rtl/ift_sram_mt.sv
// Purpose: fixed-latency SRAM with per-taint shadow memories, region poisoning and a scrub sweep.
// Latency: read data and taint appear Latency cycles after the read; writes visible next cycle.
// Backpressure: none; a request is accepted every cycle, including during a sweep.
module ift_sram_mt
    import ift_sram_pkg::*;
#(
    parameter int NumWords   = 1024,
    parameter int DataWidth  = 32,
    parameter int ByteWidth  = 8,
    parameter int NumTaints  = 2,
    parameter int Latency    = 1,
    parameter int NumRegions = 4,
    parameter int AddrWidth  = $clog2(NumWords),
    parameter int WidthBytes = (DataWidth + ByteWidth - 1) / ByteWidth,
    parameter int RegionBits = $clog2(NumRegions)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_i,
    input  logic                                  we_i,
    input  logic [AddrWidth-1:0]                  addr_i,
    input  logic [DataWidth-1:0]                  wdata_i,
    input  logic [WidthBytes-1:0]                 be_i,
    input  logic                                  clear_i,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  busy_o,
    input  logic [NumTaints-1:0]                  req_i_t0,
    input  logic [NumTaints-1:0]                  we_i_t0,
    input  logic [NumTaints-1:0][AddrWidth-1:0]   addr_i_t0,
    input  logic [NumTaints-1:0][DataWidth-1:0]   wdata_i_t0,
    input  logic [NumTaints-1:0][WidthBytes-1:0]  be_i_t0,
    output logic [NumTaints-1:0][DataWidth-1:0]   rdata_o_t0,
    output logic [NumTaints-1:0][NumRegions-1:0]  region_tainted_o
);

    // The output register supplies the last stage of latency
    localparam int PipeDepth  = Latency - 1;
    localparam int RegionIdxW = (RegionBits > 0) ? RegionBits : 1;

    // Storage and state
    logic [DataWidth-1:0]                 r_mem    [NumWords];
    logic [DataWidth-1:0]                 r_shadow [NumTaints][NumWords];
    logic [NumTaints-1:0][NumRegions-1:0] r_region;
    sweep_state_e                         r_state;
    logic [AddrWidth-1:0]                 r_cnt;
    logic [DataWidth-1:0]                 r_rdata;
    logic [NumTaints-1:0][DataWidth-1:0]  r_rdata_t0;

    // Combinational helpers
    logic                                 w_rd;
    logic                                 w_wr;
    logic                                 w_sweeping;
    logic                                 w_last;
    logic [RegionIdxW-1:0]                w_region;
    logic [DataWidth-1:0]                 w_wdata_merged;
    logic [NumTaints-1:0]                 w_sw;
    logic [NumTaints-1:0]                 w_poison;
    logic [NumTaints-1:0]                 w_poison_all;
    logic [NumTaints-1:0]                 w_rd_force;
    logic [NumTaints-1:0][DataWidth-1:0]  w_shadow_next;
    logic [NumTaints-1:0][DataWidth-1:0]  w_rd_taint;
    logic [NumTaints-1:0][NumRegions-1:0] w_region_next;
    logic [DataWidth:0]                   w_pipe_dat;
    logic [NumTaints-1:0][DataWidth-1:0]  w_pipe_taint;

    assign w_rd       = req_i & ~we_i;
    assign w_wr       = req_i & we_i;
    assign w_sweeping = (r_state == ST_SWEEP);
    assign w_last     = (r_cnt == AddrWidth'(NumWords - 1));
    assign w_region   = RegionIdxW'(region_of(32'(addr_i), AddrWidth, RegionBits));
    assign busy_o     = w_sweeping;
    assign rdata_o    = r_rdata;
    assign rdata_o_t0 = r_rdata_t0;
    assign region_tainted_o = r_region;

    // Byte-enable merge of write data into the addressed data word
    always_comb begin
        w_wdata_merged = r_mem[addr_i];
        for (int i = 0; i < DataWidth; i++) begin
            if (be_i[i / ByteWidth]) begin
                w_wdata_merged[i] = wdata_i[i];
            end
        end
    end

    // Per-taint shadow write value, region poison decision and read taint
    always_comb begin
        w_sw          = '0;
        w_poison      = '0;
        w_poison_all  = '0;
        w_rd_force    = '0;
        w_shadow_next = '0;
        w_rd_taint    = '0;
        w_region_next = '0;
        for (int k = 0; k < NumTaints; k++) begin
            w_sw[k]     = (req_i | req_i_t0[k]) & (we_i | we_i_t0[k]);
            w_poison[k] = w_sw[k] & (|(be_i | be_i_t0[k])) & (|addr_i_t0[k]);

            // A tainted region-select bit means the write could land in any region
            for (int i = 0; i < AddrWidth; i++) begin
                if (i >= AddrWidth - RegionBits) begin
                    w_poison_all[k] = w_poison_all[k] | addr_i_t0[k][i];
                end
            end

            // Tainted control/enable forces the byte to fully tainted; clean enable copies data taint
            for (int i = 0; i < DataWidth; i++) begin
                if (be_i_t0[k][i / ByteWidth] | we_i_t0[k] | req_i_t0[k]) begin
                    w_shadow_next[k][i] = 1'b1;
                end else if (be_i[i / ByteWidth]) begin
                    w_shadow_next[k][i] = wdata_i_t0[k][i];
                end else begin
                    w_shadow_next[k][i] = r_shadow[k][addr_i][i];
                end
            end

            w_rd_force[k] = (|addr_i_t0[k]) | req_i_t0[k] | (req_i & we_i_t0[k])
                          | r_region[k][w_region];
            w_rd_taint[k] = r_shadow[k][addr_i] | {DataWidth{w_rd_force[k]}};

            // Sweep completion clears flags first so a same-cycle poison still sticks
            w_region_next[k] = (w_sweeping && w_last) ? '0 : r_region[k];
            if (w_poison[k]) begin
                if (w_poison_all[k]) begin
                    w_region_next[k] = '1;
                end else begin
                    w_region_next[k][w_region] = 1'b1;
                end
            end
        end
    end

    // Data memory: byte-masked write, never reset
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[addr_i] <= w_wdata_merged;
        end
    end

    // Shadow memories: sweep zeroes the current word, a same-cycle write overrides it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumTaints; k++) begin
                for (int w = 0; w < NumWords; w++) begin
                    r_shadow[k][w] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NumTaints; k++) begin
                if (w_sweeping) begin
                    r_shadow[k][r_cnt] <= '0;
                end
                if (w_sw[k]) begin
                    r_shadow[k][addr_i] <= w_shadow_next[k];
                end
            end
        end
    end

    // Sticky region poison flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_region <= '0;
        end else begin
            r_region <= w_region_next;
        end
    end

    // Scrub FSM: walks every word once, clear_i is ignored while sweeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_i) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Read pipes: data carries the read-valid bit, taints ride alongside in lockstep
    ift_delay_line #(
        .Width (DataWidth + 1),
        .Depth (PipeDepth)
    ) u_data_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({w_rd, r_mem[addr_i]}),
        .q_o   (w_pipe_dat)
    );

    generate
        for (genvar k = 0; k < NumTaints; k++) begin : g_taint_pipe
            ift_delay_line #(
                .Width (DataWidth),
                .Depth (PipeDepth)
            ) u_taint_pipe (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (w_rd_taint[k]),
                .q_o   (w_pipe_taint[k])
            );
        end
    endgenerate

    // Output registers update only when a read completes, holding otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata    <= '0;
            r_rdata_t0 <= '0;
        end else if (w_pipe_dat[DataWidth]) begin
            r_rdata    <= w_pipe_dat[DataWidth-1:0];
            r_rdata_t0 <= w_pipe_taint;
        end
    end

endmodule
